// File: rtl/rtc_calendar_core.sv
// Calendar timekeeping core: one-second divider, Gregorian date cascade,
// valid/ready field writes with range checks, 12/24-hour display and minute alarm.
module rtc_calendar_core #(
    parameter int TICK_DIV = 50000000,
    parameter int YEAR_W   = 16,
    parameter int RST_YEAR = 2000,
    parameter int RST_WEEK = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [2:0]        set_field,
    input  logic [YEAR_W-1:0] set_value,
    output logic              set_err,
    input  logic              mode_12h,
    input  logic              alarm_en,
    input  logic [4:0]        alarm_hour,
    input  logic [5:0]        alarm_min,
    output logic [5:0]        sec,
    output logic [5:0]        min,
    output logic [4:0]        hour,
    output logic [4:0]        hour_disp,
    output logic              pm,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        week,
    output logic              sec_pulse,
    output logic              alarm_hit
);

    localparam int DIV_W = $clog2(TICK_DIV);

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        return (y[1:0] == 2'b00) &&
               (((y % YEAR_W'(100)) != '0) || ((y % YEAR_W'(400)) == '0));
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                    return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    logic [DIV_W-1:0]  r_div;
    logic              r_pending;
    logic              r_sec_pulse;
    logic              r_set_err;
    logic              r_alarm_hit;
    logic [5:0]        r_sec;
    logic [5:0]        r_min;
    logic [4:0]        r_hour;
    logic [4:0]        r_day;
    logic [3:0]        r_month;
    logic [YEAR_W-1:0] r_year;
    logic [2:0]        r_week;

    logic              w_tick;
    logic              w_accept;
    logic              w_do_adv;
    logic              w_sec_wr;
    logic [4:0]        w_cur_len;

    logic [5:0]        w_adv_sec;
    logic [5:0]        w_adv_min;
    logic [4:0]        w_adv_hour;
    logic [4:0]        w_adv_day;
    logic [3:0]        w_adv_month;
    logic [YEAR_W-1:0] w_adv_year;
    logic [2:0]        w_adv_week;

    logic              w_wr_ok;
    logic [4:0]        w_new_len;
    logic [5:0]        w_wr_sec;
    logic [5:0]        w_wr_min;
    logic [4:0]        w_wr_hour;
    logic [4:0]        w_wr_day;
    logic [3:0]        w_wr_month;
    logic [YEAR_W-1:0] w_wr_year;
    logic [2:0]        w_wr_week;

    assign w_tick    = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_accept  = set_valid & ~r_pending;
    // A tick that lands on an accepted write is replayed on the following edge.
    assign w_do_adv  = (w_tick & ~w_accept) | r_pending;
    assign w_sec_wr  = w_accept & w_wr_ok & (set_field == 3'd0);
    assign w_cur_len = month_len(r_month, is_leap(r_year));

    // One-second advance cascade computed from the current registers.
    always_comb begin
        w_adv_sec   = r_sec;
        w_adv_min   = r_min;
        w_adv_hour  = r_hour;
        w_adv_day   = r_day;
        w_adv_month = r_month;
        w_adv_year  = r_year;
        w_adv_week  = r_week;
        if (r_sec == 6'd59) begin
            w_adv_sec = 6'd0;
            if (r_min == 6'd59) begin
                w_adv_min = 6'd0;
                if (r_hour == 5'd23) begin
                    w_adv_hour = 5'd0;
                    w_adv_week = (r_week == 3'd6) ? 3'd0 : r_week + 3'd1;
                    if (r_day >= w_cur_len) begin
                        w_adv_day = 5'd1;
                        if (r_month == 4'd12) begin
                            w_adv_month = 4'd1;
                            w_adv_year  = r_year + YEAR_W'(1);
                        end else begin
                            w_adv_month = r_month + 4'd1;
                        end
                    end else begin
                        w_adv_day = r_day + 5'd1;
                    end
                end else begin
                    w_adv_hour = r_hour + 5'd1;
                end
            end else begin
                w_adv_min = r_min + 6'd1;
            end
        end else begin
            w_adv_sec = r_sec + 6'd1;
        end
    end

    // Field write decode with range check; month/year writes clamp the day.
    always_comb begin
        w_wr_ok    = 1'b0;
        w_new_len  = w_cur_len;
        w_wr_sec   = r_sec;
        w_wr_min   = r_min;
        w_wr_hour  = r_hour;
        w_wr_day   = r_day;
        w_wr_month = r_month;
        w_wr_year  = r_year;
        w_wr_week  = r_week;
        case (set_field)
            3'd0: begin
                if (set_value <= YEAR_W'(59)) begin
                    w_wr_ok  = 1'b1;
                    w_wr_sec = set_value[5:0];
                end else begin
                    w_wr_ok = 1'b0;
                end
            end
            3'd1: begin
                if (set_value <= YEAR_W'(59)) begin
                    w_wr_ok  = 1'b1;
                    w_wr_min = set_value[5:0];
                end else begin
                    w_wr_ok = 1'b0;
                end
            end
            3'd2: begin
                if (set_value <= YEAR_W'(23)) begin
                    w_wr_ok   = 1'b1;
                    w_wr_hour = set_value[4:0];
                end else begin
                    w_wr_ok = 1'b0;
                end
            end
            3'd3: begin
                if ((set_value >= YEAR_W'(1)) && (set_value <= YEAR_W'(w_cur_len))) begin
                    w_wr_ok  = 1'b1;
                    w_wr_day = set_value[4:0];
                end else begin
                    w_wr_ok = 1'b0;
                end
            end
            3'd4: begin
                if ((set_value >= YEAR_W'(1)) && (set_value <= YEAR_W'(12))) begin
                    w_wr_ok    = 1'b1;
                    w_wr_month = set_value[3:0];
                    w_new_len  = month_len(set_value[3:0], is_leap(r_year));
                    w_wr_day   = (r_day > w_new_len) ? w_new_len : r_day;
                end else begin
                    w_wr_ok = 1'b0;
                end
            end
            3'd5: begin
                w_wr_ok   = 1'b1;
                w_wr_year = set_value;
                w_new_len = month_len(r_month, is_leap(set_value));
                w_wr_day  = (r_day > w_new_len) ? w_new_len : r_day;
            end
            3'd6: begin
                if (set_value <= YEAR_W'(6)) begin
                    w_wr_ok   = 1'b1;
                    w_wr_week = set_value[2:0];
                end else begin
                    w_wr_ok = 1'b0;
                end
            end
            default: w_wr_ok = 1'b0;
        endcase
    end

    // State update: reset, then write, then (possibly deferred) advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_pending   <= 1'b0;
            r_sec_pulse <= 1'b0;
            r_set_err   <= 1'b0;
            r_alarm_hit <= 1'b0;
            r_sec       <= 6'd0;
            r_min       <= 6'd0;
            r_hour      <= 5'd0;
            r_day       <= 5'd1;
            r_month     <= 4'd1;
            r_year      <= YEAR_W'(RST_YEAR);
            r_week      <= 3'(RST_WEEK);
        end else begin
            r_sec_pulse <= w_tick;
            r_set_err   <= w_accept & ~w_wr_ok;
            r_alarm_hit <= w_do_adv & alarm_en & (w_adv_sec == 6'd0) &
                           (w_adv_min == alarm_min) & (w_adv_hour == alarm_hour);
            r_pending   <= w_tick & w_accept & ~w_sec_wr;
            if (w_sec_wr || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_accept) begin
                r_sec   <= w_wr_sec;
                r_min   <= w_wr_min;
                r_hour  <= w_wr_hour;
                r_day   <= w_wr_day;
                r_month <= w_wr_month;
                r_year  <= w_wr_year;
                r_week  <= w_wr_week;
            end else if (w_do_adv) begin
                r_sec   <= w_adv_sec;
                r_min   <= w_adv_min;
                r_hour  <= w_adv_hour;
                r_day   <= w_adv_day;
                r_month <= w_adv_month;
                r_year  <= w_adv_year;
                r_week  <= w_adv_week;
            end else begin
                r_sec   <= r_sec;
                r_min   <= r_min;
                r_hour  <= r_hour;
                r_day   <= r_day;
                r_month <= r_month;
                r_year  <= r_year;
                r_week  <= r_week;
            end
        end
    end

    assign set_ready = ~r_pending;
    assign set_err   = r_set_err;
    assign sec_pulse = r_sec_pulse;
    assign alarm_hit = r_alarm_hit;
    assign sec       = r_sec;
    assign min       = r_min;
    assign hour      = r_hour;
    assign day       = r_day;
    assign month     = r_month;
    assign year      = r_year;
    assign week      = r_week;
    assign pm        = (r_hour >= 5'd12);

    // Midnight and noon both read as 12 on a 12-hour face.
    always_comb begin
        if (!mode_12h) begin
            hour_disp = r_hour;
        end else if ((r_hour == 5'd0) || (r_hour == 5'd12)) begin
            hour_disp = 5'd12;
        end else if (r_hour > 5'd12) begin
            hour_disp = r_hour - 5'd12;
        end else begin
            hour_disp = r_hour;
        end
    end

endmodule

// File: doc/rtc_calendar_core.md
Name: rtc_calendar_core

Overview:
Parametrised timekeeping core that succeeds the fixed-width clock counter. It divides the system clock into a one-second tick. It keeps second/minute/hour/day/month/year/weekday with full Gregorian leap-year handling. It also accepts field writes through a valid/ready set port, provides 12/24-hour display outputs and raises a minute-resolution alarm pulse. It sits between the button/menu logic and the seven-segment/sound drivers.

Parameters:
TICK_DIV, 50000000, system clock cycles per second; must be >= 2.
YEAR_W, 16, year counter width; must be >= 12.
RST_YEAR, 2000, year loaded on reset; reset date is RST_YEAR-01-01.
RST_WEEK, 6, weekday loaded on reset (0=Sunday .. 6=Saturday; 2000-01-01 is Saturday).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
set_valid  in  1  field write request
set_ready  out  1  write accepted when set_valid & set_ready
set_field  in  3  0=sec 1=min 2=hour 3=day 4=month 5=year 6=week 7=reserved
set_value  in  YEAR_W  value to write; low bits used for narrow fields
set_err  out  1  one-cycle pulse: accepted write was rejected
mode_12h  in  1  selects 12-hour display format
alarm_en  in  1  enables alarm
alarm_hour  in  5  alarm hour, 0-23
alarm_min  in  6  alarm minute, 0-59
sec  out  6  seconds, 0-59
min  out  6  minutes, 0-59
hour  out  5  hours, 0-23 (always 24-hour format)
hour_disp  out  5  display hour: 24h value, or 1-12 when mode_12h
pm  out  1  1 when hour >= 12
day  out  5  day of month, 1-31
month  out  4  month, 1-12
year  out  YEAR_W  year
week  out  3  weekday, 0-6
sec_pulse  out  1  one-cycle pulse per second
alarm_hit  out  1  one-cycle pulse on alarm match

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst). Reset has priority over every other input.
- Reset values: sec=min=hour=0, day=1, month=1, year=RST_YEAR, week=RST_WEEK. Divider=0, pending=0, sec_pulse=0, set_err=0, alarm_hit=0, set_ready=1.
- Divider: counts 0..TICK_DIV-1. sec_pulse is registered and high for the cycle after the divider reaches TICK_DIV-1. The time registers advance on that same edge. The first sec_pulse after reset comes TICK_DIV cycles after rst deasserts.
- Advance cascade (one edge, all fields coherent):
  - sec 59->0 carries into min; min 59->0 carries into hour; hour 23->0 carries into day.
  - week increments modulo 7 on every day carry.
  - day wraps from month length to 1 and carries into month. Month lengths: 31/30; Feb is 29 in a leap year, else 28.
  - month 12->1 carries into year.
  - year wraps from 2^YEAR_W-1 to 0.
- Leap year: divisible by 4 and not by 100, or divisible by 400. Exact for every YEAR_W value.
- Set handshake:
  - set_ready=0 only while pending=1.
  - Write limits: sec/min 0-59; hour 0-23; day 1 to current month length; month 1-12; week 0-6; year any value.
  - An accepted in-range write updates its field on the accept edge.
  - An out-of-range write, or set_field=7, leaves all fields unchanged and pulses set_err one cycle later.
  - A write to sec also clears the divider.
- Day clamp: after a month or year write, day is clamped to the new month length on the same edge (e.g. 31 with month<-4 gives 30). Week is never recomputed automatically.
- Write/tick collision: if a write is accepted on the same edge as a tick advance:
  - the write applies and the advance is deferred; pending=1 for one cycle;
  - the advance applies on the next edge, with set_ready=0 during that cycle;
  - a sec write in the collision cancels the deferred advance (divider cleared).
- 12-hour display: hour_disp is 12 for hour 0 and for hour 12, otherwise hour mod 12. pm = (hour >= 12). Both are combinational from the registers. With mode_12h=0, hour_disp = hour.
- Alarm: alarm_hit pulses one cycle, in the same cycle as sec_pulse, when an advance produces min=alarm_min, hour=alarm_hour, sec=0 with alarm_en=1. Set writes never fire the alarm.
- Reset mid-operation: reset mid-write or mid-collision discards the write and pending, and restores all reset values on the next edge.

Test Plan:
- TICK_DIV=4, rst 1 cycle -> sec_pulse every 4 cycles, first 4 cycles after release; date 2000-01-01 00:00:00, week=6.
- Set 2000-02-28 23:59:59, one tick -> 2000-02-29 00:00:00, week+1. Set 2100-02-28 23:59:59, tick -> 2100-03-01. Set 2400-02-28 23:59:59, tick -> 2400-02-29.
- Set 1999-12-31 23:59:59, week=5, tick -> 2000-01-01 00:00:00, week=6. Set YEAR_W=12, year 4095-12-31 23:59:59, tick -> year 0, month 1, day 1.
- Write day=31, then month=4 -> day=30. Write hour=24 -> set_err pulses, hour unchanged. Write field 7 -> set_err pulses.
- Write min=10 on the tick edge from sec=59 -> min=10 first; next cycle min=11, sec=0, set_ready low for 1 cycle.
- Alarm 07:30, en=1, time 07:29:59, tick -> alarm_hit with sec_pulse. mode_12h=1: hour 0 -> disp 12, pm 0; hour 13 -> disp 1, pm 1. Assert rst mid-collision -> all reset values, pending=0.
